model_trainer_linear_matrix_receiver: RTL and testbench

//  Receiving end of the trainer-linear matrix stream (W_IN/K_IN/U_IN style): accepts a SIZE_I x SIZE_J

---
 rtl/model_trainer_linear_matrix_receiver_if.sv | 33 +++
 rtl/model_trainer_linear_matrix_receiver.sv | 112 +++++++++++
 tb/tb_model_trainer_linear_matrix_receiver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/model_trainer_linear_matrix_receiver_if.sv
// Signal bundle for the trainer-linear matrix stream receiver: load handshake, per-element acks and readback.
interface model_trainer_linear_matrix_receiver_if #(
  parameter int DATA_SIZE = 64,
  parameter int I_MAX     = 8,
  parameter int J_MAX     = 8
);
  localparam int IW = (I_MAX > 1) ? $clog2(I_MAX) : 1;
  localparam int JW = (J_MAX > 1) ? $clog2(J_MAX) : 1;

  logic                 start;
  logic                 ready;
  logic                 error;
  logic [DATA_SIZE-1:0] size_i_in;
  logic [DATA_SIZE-1:0] size_j_in;
  logic                 data_in_i_enable;
  logic                 data_in_j_enable;
  logic [DATA_SIZE-1:0] data_in;
  logic                 data_out_i_enable;
  logic                 data_out_j_enable;
  logic [IW-1:0]        rd_i;
  logic [JW-1:0]        rd_j;
  logic [DATA_SIZE-1:0] rd_data;

  modport master (
    output start, size_i_in, size_j_in, data_in_i_enable, data_in_j_enable, data_in, rd_i, rd_j,
    input  ready, error, data_out_i_enable, data_out_j_enable, rd_data
  );

  modport slave (
    input  start, size_i_in, size_j_in, data_in_i_enable, data_in_j_enable, data_in, rd_i, rd_j,
    output ready, error, data_out_i_enable, data_out_j_enable, rd_data
  );
endinterface

// File: rtl/model_trainer_linear_matrix_receiver.sv
// Receives a SIZE_I x SIZE_J matrix row-major into a local buffer, acking each element and
// pulsing ready once the last element lands. Buffer is readable at any time with one cycle latency.
//
// state | meaning
// IDLE  | waiting for start with legal sizes
// LOAD  | accepting elements, counters track next (i,j)
module model_trainer_linear_matrix_receiver #(
  parameter int DATA_SIZE = 64,
  parameter int I_MAX     = 8,
  parameter int J_MAX     = 8
) (
  input logic clk,
  input logic rst_n,
  model_trainer_linear_matrix_receiver_if.slave bus
);
  localparam int IW = (I_MAX > 1) ? $clog2(I_MAX) : 1;
  localparam int JW = (J_MAX > 1) ? $clog2(J_MAX) : 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        cnt_i, last_i;
  logic [JW-1:0]        cnt_j, last_j;
  logic [DATA_SIZE-1:0] mem [I_MAX][J_MAX];

  logic sizes_ok, row_end, rd_hit;
  logic start_ok, start_bad, accept, bad_mark, done;

  // Range check happens at full width so oversized values cannot alias into range after truncation.
  assign sizes_ok = (bus.size_i_in != '0) && (bus.size_i_in <= DATA_SIZE'(I_MAX)) &&
                    (bus.size_j_in != '0) && (bus.size_j_in <= DATA_SIZE'(J_MAX));
  assign row_end  = (cnt_j == last_j);
  assign rd_hit   = (32'(bus.rd_i) < I_MAX) && (32'(bus.rd_j) < J_MAX);

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    accept    = 1'b0;
    bad_mark  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (sizes_ok) begin
            start_ok  = 1'b1;
            state_nxt = LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.data_in_j_enable) begin
          if (bus.data_in_i_enable == (cnt_j == '0)) begin
            accept = 1'b1;
            if (row_end && (cnt_i == last_i)) begin
              done      = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            bad_mark = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      cnt_i                 <= '0;
      cnt_j                 <= '0;
      last_i                <= '0;
      last_j                <= '0;
      bus.ready             <= 1'b0;
      bus.error             <= 1'b0;
      bus.data_out_i_enable <= 1'b0;
      bus.data_out_j_enable <= 1'b0;
      bus.rd_data           <= '0;
    end else begin
      state                 <= state_nxt;
      bus.ready             <= done;
      bus.data_out_j_enable <= accept;
      bus.data_out_i_enable <= accept && row_end;
      if (start_ok) begin
        last_i    <= IW'(bus.size_i_in - DATA_SIZE'(1));
        last_j    <= JW'(bus.size_j_in - DATA_SIZE'(1));
        cnt_i     <= '0;
        cnt_j     <= '0;
        bus.error <= 1'b0;
      end else if (start_bad || bad_mark) begin
        bus.error <= 1'b1;
      end
      if (accept) begin
        if (row_end) begin
          cnt_j <= '0;
          cnt_i <= done ? '0 : cnt_i + IW'(1);
        end else begin
          cnt_j <= cnt_j + JW'(1);
        end
      end
      bus.rd_data <= rd_hit ? mem[bus.rd_i][bus.rd_j] : '0;
    end
  end

  // Buffer deliberately has no reset so contents survive an abandoned load.
  always_ff @(posedge clk) begin
    if (accept) mem[cnt_i][cnt_j] <= bus.data_in;
  end
endmodule

// File: tb/tb_model_trainer_linear_matrix_receiver.sv
// Scoreboard bench for the matrix receiver: directed scenarios plus randomized loads against a
// linear-index reference model.
module tb_model_trainer_linear_matrix_receiver;
  localparam int DW = 64;
  localparam int IM = 8;
  localparam int JM = 8;
  localparam int AW = $clog2(IM);
  localparam int BW = $clog2(JM);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  model_trainer_linear_matrix_receiver_if #(.DATA_SIZE(DW), .I_MAX(IM), .J_MAX(JM)) bus ();
  model_trainer_linear_matrix_receiver #(.DATA_SIZE(DW), .I_MAX(IM), .J_MAX(JM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {logic ack_i; logic ready;} ack_t;

  int n_pass = 0;
  int n_total = 0;
  ack_t exp_q[$];
  ack_t mon_a;

  // Reference: element k of a load goes to row k/SIZE_J, column k%SIZE_J.
  logic [DW-1:0] ref_mem [IM][JM];
  bit            ref_ok  [IM][JM];
  bit            m_load = 1'b0;
  bit            m_err = 1'b0;
  int            m_k = 0, m_si = 0, m_sj = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic step(input bit se, input logic [DW-1:0] si, input logic [DW-1:0] sj,
                      input bit ie, input bit je, input logic [DW-1:0] d);
    logic [DW-1:0] rd_exp;
    bit rd_known, acc;
    int row, col;
    ack_t a;
    bus.start = se; bus.size_i_in = si; bus.size_j_in = sj;
    bus.data_in_i_enable = ie; bus.data_in_j_enable = je; bus.data_in = d;
    bus.rd_i = AW'($urandom_range(0, IM - 1));
    bus.rd_j = BW'($urandom_range(0, JM - 1));
    rd_exp   = ref_mem[bus.rd_i][bus.rd_j];
    rd_known = ref_ok[bus.rd_i][bus.rd_j];
    acc = 1'b0;
    if (se && !m_load) begin
      if (si >= 64'd1 && si <= 64'(IM) && sj >= 64'd1 && sj <= 64'(JM)) begin
        m_load = 1'b1; m_k = 0; m_si = int'(si); m_sj = int'(sj); m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (m_load && je) begin
      row = m_k / m_sj;
      col = m_k % m_sj;
      if (ie == (col == 0)) begin
        acc = 1'b1;
        ref_mem[row][col] = d;
        ref_ok[row][col] = 1'b1;
        m_k++;
        a.ack_i = (col == m_sj - 1);
        a.ready = (m_k == m_si * m_sj);
        if (a.ready) m_load = 1'b0;
        exp_q.push_back(a);
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("ack_j_timing", 64'(bus.data_out_j_enable), 64'(acc));
    check("error", 64'(bus.error), 64'(m_err));
    if (rd_known) check("rd_data_random", bus.rd_data, rd_exp);
  endtask

  task automatic start_load(input logic [DW-1:0] si, input logic [DW-1:0] sj);
    step(1'b1, si, sj, 1'b0, 1'b0, '0);
  endtask

  task automatic elem(input bit ie, input logic [DW-1:0] d);
    step(1'b0, '0, '0, ie, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, '0, '0, 1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom});
  endtask

  task automatic readback(input int i, input int j, input logic [DW-1:0] req);
    bus.start = 1'b0; bus.data_in_j_enable = 1'b0; bus.data_in_i_enable = 1'b0;
    bus.rd_i = AW'(i); bus.rd_j = BW'(j);
    @(posedge clk); #1;
    check($sformatf("readback[%0d][%0d]", i, j), bus.rd_data, req);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ack_j", 64'(bus.data_out_j_enable), 64'd0);
    check("rst_ack_i", 64'(bus.data_out_i_enable), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);
    exp_q.delete();
    m_load = 1'b0; m_err = 1'b0; m_k = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_out_j_enable) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ack: j ack seen, expected none (scoreboard empty) at %0t", $time);
        end else begin
          mon_a = exp_q.pop_front();
          check("ack_i", 64'(bus.data_out_i_enable), 64'(mon_a.ack_i));
          check("ready", 64'(bus.ready), 64'(mon_a.ready));
        end
      end else if (bus.data_out_i_enable || bus.ready) begin
        n_total++;
        $display("FAIL stray_pulse: i_ack=%0b ready=%0b without j ack, expected 0 0 at %0t",
                 bus.data_out_i_enable, bus.ready, $time);
      end
    end
  end

  initial begin
    bit ie;
    int guard;
    logic [DW-1:0] si, sj;
    bus.start = 1'b0; bus.size_i_in = '0; bus.size_j_in = '0;
    bus.data_in_i_enable = 1'b0; bus.data_in_j_enable = 1'b0; bus.data_in = '0;
    bus.rd_i = '0; bus.rd_j = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_error", 64'(bus.error), 64'd0);
    check("reset_ack_j", 64'(bus.data_out_j_enable), 64'd0);
    check("reset_ack_i", 64'(bus.data_out_i_enable), 64'd0);
    check("reset_rd_data", bus.rd_data, 64'd0);
    rst_n = 1'b1;

    // T1: 2x3 back-to-back
    start_load(2, 3);
    elem(1, 1); elem(0, 2); elem(0, 3); elem(1, 4); elem(0, 5); elem(0, 6);
    idle(1);
    readback(1, 2, 64'd6);
    readback(0, 0, 64'd1);

    // T2: same matrix with gaps
    start_load(2, 3);
    for (int k = 0; k < 6; k++) begin
      elem(k % 3 == 0, 64'(k + 1));
      idle(2);
    end
    readback(1, 0, 64'd4);

    // T3: mis-marked element is dropped and error sticks through completion
    start_load(2, 3);
    elem(1, 1); elem(1, 2); elem(0, 2); elem(0, 3); elem(1, 4); elem(0, 5); elem(0, 6);
    idle(2);

    // T4: illegal sizes, including one that aliases to a legal value if truncated
    start_load(0, 3);        idle(1);
    start_load(2, JM + 1);   idle(1);
    start_load(64'h1_0000_0002, 2); idle(1);
    start_load(IM + 1, 1);   idle(1);

    // T5: start during load is ignored
    start_load(2, 3);
    elem(1, 11); elem(0, 12); elem(0, 13);
    start_load(1, 1);
    elem(1, 14); elem(0, 15); elem(0, 16);
    idle(1);
    readback(1, 2, 64'd16);

    // T6: reset mid-load, buffer survives
    start_load(2, 3);
    elem(1, 1); elem(0, 2); elem(0, 3); elem(1, 4);
    pulse_reset();
    start_load(1, 1);
    elem(1, 64'hAB);
    idle(1);
    readback(0, 0, 64'hAB);
    readback(0, 2, 64'd3);

    // Back-to-back loads: start in the ready cycle, max-size boundary
    start_load(1, 2);
    elem(1, 64'h21); elem(0, 64'h22);
    start_load(IM, JM);
    for (int k = 0; k < IM * JM; k++) elem(k % JM == 0, {$urandom, $urandom});
    idle(1);

    // Randomized loads with gaps, mis-marks, stray starts and illegal sizes
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        start_load($urandom_range(0, 1) ? 64'd0 : 64'(JM + $urandom_range(1, 3)), 64'($urandom_range(1, JM)));
        idle(1);
      end
      si = 64'($urandom_range(1, IM));
      sj = 64'($urandom_range(1, JM));
      start_load(si, sj);
      guard = 0;
      while (m_load && guard < 600) begin
        guard++;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          if ($urandom_range(0, 7) == 0) start_load(64'($urandom_range(1, IM)), 64'($urandom_range(1, JM)));
          else idle(1);
        end
        ie = (m_k % m_sj == 0);
        if ($urandom_range(0, 9) == 0) ie = !ie;
        elem(ie, {$urandom, $urandom});
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
